// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//
// Multi-cycle integer divide/remainder unit for the EX stage of an in-order
// pipeline (RV32M DIV, DIVU, REM, REMU). One restoring radix-2 step is done
// per cycle on operand magnitudes. The sign is applied once, when the result
// is written into the output register. Division by zero and signed overflow
// skip the iteration and finish one cycle after the operation is accepted.
//
// Ports
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous active-high reset
//   start   in   1  divide/remainder instruction valid in EX
//   func3   in   3  100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a    in  32  dividend (forwarded)
//   op_b    in  32  divisor (forwarded)
//   flush   in   1  abort any operation in progress
//   stall   out  1  freezes PC, IF/ID and ID/EX while the divide runs
//   busy    out  1  high exactly while iterating
//   done    out  1  one-cycle pulse; result is valid
//   result  out 32  quotient or remainder, held until the next done
// -----------------------------------------------------------------------------
module div_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [31:0] rem_reg, rem_next;
    logic [31:0] quot_reg, quot_next;
    logic [31:0] divisor_reg, divisor_next;
    logic        q_sign_reg, q_sign_next;
    logic        r_sign_reg, r_sign_next;
    logic        is_rem_reg, is_rem_next;
    logic        is_signed_reg, is_signed_next;
    logic [31:0] result_reg, result_next;

    // ---------------------------------------------------------------------
    // Operand decode at accept time
    // ---------------------------------------------------------------------
    logic        op_signed;
    logic        op_rem;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        overflow;
    logic [31:0] special_val;
    logic        accept;
    // func3[2] is always set for this instruction group; it is not decoded.
    logic        unused_func3_msb;

    assign unused_func3_msb = func3[2];
    assign op_signed = ~func3[0];
    assign op_rem    = func3[1];
    assign a_neg     = op_signed & op_a[31];
    assign b_neg     = op_signed & op_b[31];
    assign a_mag     = a_neg ? (32'd0 - op_a) : op_a;
    assign b_mag     = b_neg ? (32'd0 - op_b) : op_b;
    assign div_zero  = (op_b == 32'd0);
    assign overflow  = op_signed & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);

    // Architecturally defined results for the two corner cases; the
    // remainder on divide-by-zero is the raw dividend, not its magnitude.
    always_comb begin
        special_val = 32'd0;
        if (div_zero) begin
            special_val = op_rem ? op_a : 32'hFFFF_FFFF;
        end else begin
            special_val = op_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    assign accept = (state_reg == S_IDLE) & start & ~flush;

    // ---------------------------------------------------------------------
    // One restoring step: {rem,quot} << 1, then a 33-bit trial subtract.
    // The partial remainder is always below the divisor, so the kept value
    // fits in 32 bits; bit 32 of the trial result is the borrow.
    // ---------------------------------------------------------------------
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic        step_ok;
    logic [31:0] rem_step;
    logic [31:0] quot_step;
    logic [31:0] final_mag;
    logic        final_neg;
    logic [31:0] final_val;

    assign rem_shift = {rem_reg, quot_reg[31]};
    assign trial     = rem_shift - {1'b0, divisor_reg};
    assign step_ok   = ~trial[32];
    assign rem_step  = step_ok ? trial[31:0] : rem_shift[31:0];
    assign quot_step = {quot_reg[30:0], step_ok};

    // Sign correction uses the post-step values so the corrected result can
    // be registered on the last BUSY edge and be stable throughout DONE.
    assign final_mag = is_rem_reg ? rem_step : quot_step;
    assign final_neg = is_signed_reg & (is_rem_reg ? r_sign_reg : q_sign_reg);
    assign final_val = final_neg ? (32'd0 - final_mag) : final_mag;

    // ---------------------------------------------------------------------
    // Next-state and datapath update
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rem_next       = rem_reg;
        quot_next      = quot_reg;
        divisor_next   = divisor_reg;
        q_sign_next    = q_sign_reg;
        r_sign_next    = r_sign_reg;
        is_rem_next    = is_rem_reg;
        is_signed_next = is_signed_reg;
        result_next    = result_reg;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    is_rem_next    = op_rem;
                    is_signed_next = op_signed;
                    q_sign_next    = a_neg ^ b_neg;
                    r_sign_next    = a_neg;
                    divisor_next   = b_mag;
                    rem_next       = 32'd0;
                    quot_next      = a_mag;
                    cnt_next       = 5'd0;
                    if (div_zero || overflow) begin
                        result_next = special_val;
                        state_next  = S_DONE;
                    end else begin
                        state_next  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                rem_next  = rem_step;
                quot_next = quot_step;
                cnt_next  = cnt_reg + 5'd1;
                if (cnt_reg == 5'd31) begin
                    result_next = final_val;
                    state_next  = S_DONE;
                end
            end
            S_DONE: begin
                // A start arriving here is ignored; it is re-presented in
                // IDLE because stall is low and the pipeline has moved on.
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Flush wins over everything except reset and leaves result alone,
        // including when the final BUSY step would have written it.
        if (flush) begin
            state_next  = S_IDLE;
            result_next = result_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= 5'd0;
            rem_reg       <= 32'd0;
            quot_reg      <= 32'd0;
            divisor_reg   <= 32'd0;
            q_sign_reg    <= 1'b0;
            r_sign_reg    <= 1'b0;
            is_rem_reg    <= 1'b0;
            is_signed_reg <= 1'b0;
            result_reg    <= 32'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rem_reg       <= rem_next;
            quot_reg      <= quot_next;
            divisor_reg   <= divisor_next;
            q_sign_reg    <= q_sign_next;
            r_sign_reg    <= r_sign_next;
            is_rem_reg    <= is_rem_next;
            is_signed_reg <= is_signed_next;
            result_reg    <= result_next;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign stall  = accept | (state_reg == S_BUSY);
    assign busy   = (state_reg == S_BUSY);
    assign done   = (state_reg == S_DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
//
// Self-checking bench for div_sequencer. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled a further unit later. Expected
// results come from an arithmetic model of the RV32M divide rules.
// -----------------------------------------------------------------------------
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_result;

    div_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // RV32M reference: plain arithmetic plus the two architectural corner cases.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               sgn;
        logic               want_rem;
        sgn      = (f3[0] == 1'b0);
        want_rem = f3[1];
        sa = a;
        sb = b;
        if (b == 32'd0)
            return want_rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return want_rem ? 32'd0 : 32'h8000_0000;
        if (sgn)
            return want_rem ? 32'(sa % sb) : 32'(sa / sb);
        return want_rem ? (a % b) : (a / b);
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (f3[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drives one operation starting in an IDLE cycle (called at posedge+1)
    // and returns at posedge+1 of the DONE cycle, or after a 40-cycle bound.
    // stall_ok collects: stall high in the start cycle and every BUSY cycle,
    // busy high while waiting, stall low in DONE.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit stall_ok);
        start = 1'b1;
        func3 = f3;
        op_a  = a;
        op_b  = b;
        #1;
        stall_ok = (stall === 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (stall !== 1'b0 || busy !== 1'b0) stall_ok = 1'b0;
        res = result;
        $display("op func3=%b a=%h b=%h result=%h latency=%0d", f3, a, b, res, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; flush = 1'b0; func3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_priority: busy=%b done=%b result=%h required 0 0 00000000", busy, done, result);
        end
        start = 1'b0; rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b busy=%b done=%b result=%h required all 0", stall, busy, done, result);
        end
        // Flush in the same cycle as start: no accept, no stall.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_stall: stall=%b required 0", stall);
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_start: busy=%b done=%b required 0 0", busy, done);
        end
        last_result = 32'd0;
    endtask

    task automatic test_directed();
        logic [2:0]  tf3 [9] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b110,
                                 3'b100, 3'b111, 3'b100, 3'b110};
        logic [31:0] ta  [9] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                                 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb  [9] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tex [9] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int          tlat[9] = '{33, 33, 33, 33, 33, 1, 1, 1, 1};
        logic [31:0] res;
        int          lat;
        bit          sok;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            run_op(tf3[i], ta[i], tb[i], res, lat, sok);
            checks++;
            if (res !== tex[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, res, tex[i]);
            end
            checks++;
            if (lat != tlat[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, tlat[i]);
            end
            checks++;
            if (!sok) begin
                errors++;
                $display("FAIL directed_stall[%0d]: stall/busy profile wrong, got 0 required 1", i);
            end
            last_result = tex[i];
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        bit          sok;
        bit          saw_done;
        @(posedge clk); #1;
        start = 1'b1; func3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== last_result) begin
            errors++;
            $display("FAIL flush_abort: busy=%b done=%b stall=%b result=%h required 0 0 0 %h",
                     busy, done, stall, result, last_result);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL flush_quiet: got activity after flush, required none");
        end
        run_op(3'b100, 32'd1000, 32'hFFFF_FFFD, res, lat, sok);
        checks++;
        if (res !== model(3'b100, 32'd1000, 32'hFFFF_FFFD) || lat != 33) begin
            errors++;
            $display("FAIL flush_restart: got %h lat %0d required %h lat 33",
                     res, lat, model(3'b100, 32'd1000, 32'hFFFF_FFFD));
        end
        last_result = res;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        bit          sok;
        bit          extra;
        @(posedge clk); #1;
        run_op(3'b101, 32'd100, 32'd7, res, lat, sok);
        checks++;
        if (res !== 32'd14 || lat != 33) begin
            errors++;
            $display("FAIL b2b_first: got %h lat %0d required 0000000e lat 33", res, lat);
        end
        // Start presented during DONE must be ignored.
        start = 1'b1; func3 = 3'b101; op_a = 32'd9; op_b = 32'd3;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL done_ignores_start: busy=%b done=%b required 0 0", busy, done);
        end
        // Second divide accepted in the IDLE cycle right after DONE.
        run_op(3'b101, 32'd50, 32'd5, res, lat, sok);
        checks++;
        if (res !== 32'd10 || lat != 33 || !sok) begin
            errors++;
            $display("FAIL b2b_second: got %h lat %0d stall_ok %0d required 0000000a lat 33 stall_ok 1",
                     res, lat, sok);
        end
        last_result = res;
        extra = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL b2b_no_third: got activity, required none");
        end
    endtask

    task automatic test_reset_mid_busy();
        bit saw;
        @(posedge clk); #1;
        start = 1'b1; func3 = 3'b111; op_a = $urandom; op_b = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_busy: busy=%b done=%b stall=%b result=%h required 0 0 0 00000000",
                     busy, done, stall, result);
        end
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL reset_no_done: got done pulse, required none");
        end
        last_result = 32'd0;
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        bit          sok;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'(4 + $urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 16));
                3: a = 32'($urandom_range(0, 16));
                4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            @(posedge clk); #1;
            run_op(f3, a, b, res, lat, sok);
            checks++;
            if (res !== model(f3, a, b) || lat != model_lat(f3, a, b) || !sok) begin
                errors++;
                $display("FAIL random[%0d] f3=%b a=%h b=%h: got %h lat %0d stall_ok %0d required %h lat %0d stall_ok 1",
                         i, f3, a, b, res, lat, sok, model(f3, a, b), model_lat(f3, a, b));
            end
            last_result = model(f3, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
